// File: rtl/gearbox_rx_if.sv
// rtl/gearbox_rx_if.sv - word/slip input and block output bundle for gearbox_rx
interface gearbox_rx_if #(
    parameter int DATA_W = 64,
    parameter int HEAD_W = 2
);
    logic              data_v_i;
    logic [DATA_W-1:0] data_i;
    logic              slip_i;
    logic              valid_o;
    logic [HEAD_W-1:0] head_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output data_v_i, data_i, slip_i,
        input  valid_o, head_o, data_o
    );

    modport slave (
        input  data_v_i, data_i, slip_i,
        output valid_o, head_o, data_o
    );
endinterface

// File: rtl/gearbox_rx.sv
// rtl/gearbox_rx.sv - 64b word to 66b block receive gearbox with bit slip; GEARBOX_RX_SLIP_GUARD_EN adds a slip guard
module gearbox_rx #(
    parameter int DATA_W = 64,
    parameter int HEAD_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    gearbox_rx_if.slave   bus
);
    localparam int BLOCK_W = HEAD_W + DATA_W;
    localparam int BUF_W   = BLOCK_W + DATA_W - 1;
    localparam int CNT_W   = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_fill;
    logic              r_valid;
    logic [HEAD_W-1:0] r_head;
    logic [DATA_W-1:0] r_data;

    logic [BUF_W-1:0]  w_ext;
    logic [BUF_W-1:0]  w_cat;
    logic [BUF_W-1:0]  w_stream;
    logic [CNT_W-1:0]  w_total;
    logic              w_slip;
    logic              w_emit;

`ifdef GEARBOX_RX_SLIP_GUARD_EN
    logic [5:0] r_guard;

    assign w_slip = bus.slip_i & bus.data_v_i & (r_guard == 6'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_guard <= 6'd0;
        end else if (bus.data_v_i) begin
            if (w_slip)
                r_guard <= 6'd32;
            else if (r_guard != 6'd0)
                r_guard <= r_guard - 6'd1;
        end
    end
`else
    assign w_slip = bus.slip_i & bus.data_v_i;
`endif

    // Bits above r_fill are always zero, so the new word can simply be OR-ed in
    // above the buffered bits; a slip drops the oldest bit of the joined stream,
    // which is data_i[0] when the buffer is empty.
    always_comb begin
        w_ext                = '0;
        w_ext[DATA_W-1:0]    = bus.data_i;
        w_cat                = r_buf | (w_ext << r_fill);
        w_stream             = w_slip ? (w_cat >> 1) : w_cat;
        w_total              = r_fill + CNT_W'(DATA_W) - {{(CNT_W-1){1'b0}}, w_slip};
        w_emit               = (w_total >= CNT_W'(BLOCK_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.data_v_i) begin
                if (w_emit) begin
                    r_head  <= w_stream[HEAD_W-1:0];
                    r_data  <= w_stream[BLOCK_W-1:HEAD_W];
                    r_buf   <= w_stream >> BLOCK_W;
                    r_fill  <= w_total - CNT_W'(BLOCK_W);
                    r_valid <= 1'b1;
                end else begin
                    r_buf   <= w_stream;
                    r_fill  <= w_total;
                end
            end
        end
    end

    assign bus.valid_o = r_valid;
    assign bus.head_o  = r_head;
    assign bus.data_o  = r_data;
endmodule
